// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Two-requester round-robin front end for a single uart_tx. Accepts one byte
// at a time in IDLE, fires a one-cycle start pulse, then shadows the frame by
// counting baud ticks (trigger_i) so a new start is never issued while uart_tx
// is still shifting, plus a programmable idle gap between frames.
//
// Ports
//   clk_i, rst_i             clock, asynchronous active-high reset
//   trigger_i                baud tick shared with uart_tx
//   reqN_valid_i/data_i/crc_en_i   requester N byte, pending flag, CRC request
//   reqN_ready_o             handshake; acceptance when ready & valid
//   data_o, crc_en_o         latched byte / CRC flag for uart_tx
//   tx_start_cmd_o           one-cycle start pulse
//   busy_o                   high whenever a frame (or its gap) is in flight
//   grant_o                  owner of the current or most recent frame
module uart_tx_scheduler #(
    parameter int FRAME_TICKS     = 11,
    parameter int FRAME_TICKS_CRC = 19,
    parameter int GAP_TICKS       = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       trigger_i,
    input  logic       req0_valid_i,
    input  logic       req1_valid_i,
    input  logic [7:0] req0_data_i,
    input  logic [7:0] req1_data_i,
    input  logic       req0_crc_en_i,
    input  logic       req1_crc_en_i,
    output logic       req0_ready_o,
    output logic       req1_ready_o,
    output logic [7:0] data_o,
    output logic       crc_en_o,
    output logic       tx_start_cmd_o,
    output logic       busy_o,
    output logic       grant_o
);

    typedef enum logic [1:0] {IDLE, LAUNCH, SENDING, GAP} state_t;

    localparam logic [5:0] FT_LAST  = 6'(FRAME_TICKS);
    localparam logic [5:0] FTC_LAST = 6'(FRAME_TICKS_CRC);
    localparam logic [5:0] GAP_LAST = 6'(GAP_TICKS);

    state_t     state, state_nxt;
    logic [4:0] cnt, cnt_nxt;
    logic [5:0] cnt_inc;
    logic       sel;
    logic       accept;
    logic       frame_last;
    logic       gap_last;

    // One extra bit so the terminal compare never sees a wrapped value.
    assign cnt_inc    = {1'b0, cnt} + 6'd1;
    assign frame_last = (cnt_inc == (crc_en_o ? FTC_LAST : FT_LAST));
    assign gap_last   = (cnt_inc == GAP_LAST);

    // Tie goes to the requester that did not own the last frame.
    always_comb begin
        if (req0_valid_i && req1_valid_i)
            sel = ~grant_o;
        else
            sel = req1_valid_i;
    end

    assign accept         = (state == IDLE) && (req0_valid_i || req1_valid_i);
    assign req0_ready_o   = (state == IDLE) && req0_valid_i && !sel;
    assign req1_ready_o   = (state == IDLE) && req1_valid_i && sel;
    assign tx_start_cmd_o = (state == LAUNCH);
    assign busy_o         = (state != IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = LAUNCH;
            end
            LAUNCH: begin
                // A tick seen in this cycle belongs to uart_tx's own start
                // handling and is deliberately not counted.
                cnt_nxt   = '0;
                state_nxt = SENDING;
            end
            SENDING: begin
                if (trigger_i) begin
                    if (frame_last) begin
                        cnt_nxt   = '0;
                        state_nxt = (GAP_TICKS == 0) ? IDLE : GAP;
                    end else begin
                        cnt_nxt = cnt + 5'd1;
                    end
                end
            end
            GAP: begin
                if (trigger_i) begin
                    if (gap_last) begin
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + 5'd1;
                    end
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            data_o   <= '0;
            crc_en_o <= 1'b0;
            grant_o  <= 1'b1;   // req0 wins the first tie
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                data_o   <= sel ? req1_data_i : req0_data_i;
                crc_en_o <= sel ? req1_crc_en_i : req0_crc_en_i;
                grant_o  <= sel;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trig = 1'b0;
    logic       v0 = 1'b0, v1 = 1'b0, c0 = 1'b0, c1 = 1'b0;
    logic [7:0] d0 = 8'h00, d1 = 8'h00;
    logic       r0, r1, crc, start, busy, grant;
    logic [7:0] data;

    // Second instance with no inter-frame gap.
    logic       z_trig = 1'b0, z_v0 = 1'b0, z_v1 = 1'b0, z_c0 = 1'b0, z_c1 = 1'b0;
    logic [7:0] z_d0 = 8'h00, z_d1 = 8'h00;
    logic       z_r0, z_r1, z_crc, z_start, z_busy, z_grant;
    logic [7:0] z_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_scheduler dut (
        .clk_i(clk), .rst_i(rst), .trigger_i(trig),
        .req0_valid_i(v0), .req1_valid_i(v1),
        .req0_data_i(d0), .req1_data_i(d1),
        .req0_crc_en_i(c0), .req1_crc_en_i(c1),
        .req0_ready_o(r0), .req1_ready_o(r1),
        .data_o(data), .crc_en_o(crc), .tx_start_cmd_o(start),
        .busy_o(busy), .grant_o(grant)
    );

    uart_tx_scheduler #(.GAP_TICKS(0)) dut_nogap (
        .clk_i(clk), .rst_i(rst), .trigger_i(z_trig),
        .req0_valid_i(z_v0), .req1_valid_i(z_v1),
        .req0_data_i(z_d0), .req1_data_i(z_d1),
        .req0_crc_en_i(z_c0), .req1_crc_en_i(z_c1),
        .req0_ready_o(z_r0), .req1_ready_o(z_r1),
        .data_o(z_data), .crc_en_o(z_crc), .tx_start_cmd_o(z_start),
        .busy_o(z_busy), .grant_o(z_grant)
    );

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        v0 = 0; v1 = 0;
        do_reset();
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %0h exp 0", data); end
        checks++; if (crc !== 1'b0) begin errors++; $display("FAIL reset_crc got %0b exp 0", crc); end
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start got %0b exp 0", start); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (grant !== 1'b1) begin errors++; $display("FAIL reset_grant got %0b exp 1", grant); end
        checks++; if ({r0, r1} !== 2'b00) begin errors++; $display("FAIL reset_ready got %0b exp 0", {r0, r1}); end
    endtask

    // Single req0 frame; busy must fall right after the 11 frame + 1 gap ticks.
    task automatic test_basic();
        int n;
        do_reset();
        v0 = 1; d0 = 8'hA5; c0 = 0; v1 = 0; trig = 0;
        #1;
        checks++; if ({r0, r1} !== 2'b10) begin errors++; $display("FAIL basic_ready got %0b exp 10", {r0, r1}); end
        cyc();
        checks++; if (start !== 1'b1) begin errors++; $display("FAIL basic_start got %0b exp 1", start); end
        checks++; if (data !== 8'hA5) begin errors++; $display("FAIL basic_data got %0h exp a5", data); end
        checks++; if (grant !== 1'b0) begin errors++; $display("FAIL basic_grant got %0b exp 0", grant); end
        v0 = 0;
        trig = 1;   // tick during launch must be ignored
        cyc();
        n = 0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after_launch got %0b exp 1", busy); end
        while (n < 12) begin
            trig = 1'($urandom);
            cyc();
            if (trig) n++;
            checks++; if (busy !== (n < 12)) begin errors++; $display("FAIL basic_busy tick %0d got %0b exp %0b", n, busy, (n < 12)); end
            checks++; if (start !== 1'b0) begin errors++; $display("FAIL basic_extra_start got %0b exp 0", start); end
        end
        trig = 0;
    endtask

    // Both valid continuously: strict alternation, spacing 2+11+1 with trigger high.
    task automatic test_round_robin();
        int t[$];
        do_reset();
        v0 = 1; v1 = 1; d0 = 8'h11; d1 = 8'h22; c0 = 0; c1 = 0; trig = 1;
        for (int k = 0; k < 4; k++) begin
            int g;
            g = 0;
            while (start !== 1'b1 && g < 100) begin cyc(); g++; end
            checks++; if (start !== 1'b1) begin errors++; $display("FAIL rr_timeout frame %0d got %0b exp 1", k, start); end
            t.push_back($time / 10);
            checks++; if (data !== ((k % 2) ? 8'h22 : 8'h11)) begin errors++; $display("FAIL rr_data frame %0d got %0h exp %0h", k, data, (k % 2) ? 8'h22 : 8'h11); end
            checks++; if (grant !== 1'(k % 2)) begin errors++; $display("FAIL rr_grant frame %0d got %0b exp %0b", k, grant, k % 2); end
            cyc();
        end
        for (int k = 1; k < t.size(); k++) begin
            checks++; if (t[k] - t[k-1] !== 14) begin errors++; $display("FAIL rr_spacing got %0d exp 14", t[k] - t[k-1]); end
        end
        v0 = 0; v1 = 0;
        for (int g = 0; g < 40 && busy; g++) cyc();
        trig = 0;
    endtask

    // Random requests, data, CRC and trigger against a transaction-level model.
    task automatic test_random();
        logic last_grant, exp_sel, exp_c;
        logic [7:0] exp_d;
        logic [1:0] rr;
        int total, n;
        do_reset();
        last_grant = 1'b1;
        for (int f = 0; f < 24; f++) begin
            rr = 2'($urandom_range(1, 3));
            v0 = rr[0]; v1 = rr[1];
            d0 = 8'($urandom); d1 = 8'($urandom);
            c0 = 1'($urandom); c1 = 1'($urandom);
            exp_sel = (v0 && v1) ? !last_grant : v1;
            exp_d = exp_sel ? d1 : d0;
            exp_c = exp_sel ? c1 : c0;
            trig = 1'($urandom);
            #1;
            checks++; if ({r0, r1} !== {v0 && !exp_sel, v1 && exp_sel}) begin errors++; $display("FAIL rand_ready frame %0d got %0b exp %0b", f, {r0, r1}, {v0 && !exp_sel, v1 && exp_sel}); end
            cyc();
            checks++; if (start !== 1'b1) begin errors++; $display("FAIL rand_start frame %0d got %0b exp 1", f, start); end
            checks++; if (grant !== exp_sel) begin errors++; $display("FAIL rand_grant frame %0d got %0b exp %0b", f, grant, exp_sel); end
            last_grant = exp_sel;
            total = (exp_c ? 19 : 11) + 1;
            n = 0;
            trig = 1'($urandom);   // consumed by the launch cycle
            while (n < total) begin
                v0 = 1'($urandom); v1 = 1'($urandom);
                #1;
                checks++; if ({r0, r1} !== 2'b00) begin errors++; $display("FAIL rand_busy_ready frame %0d got %0b exp 00", f, {r0, r1}); end
                cyc();
                checks++; if (data !== exp_d || crc !== exp_c) begin errors++; $display("FAIL rand_hold frame %0d got %0h/%0b exp %0h/%0b", f, data, crc, exp_d, exp_c); end
                checks++; if (start !== 1'b0) begin errors++; $display("FAIL rand_extra_start frame %0d got %0b exp 0", f, start); end
                checks++; if (busy !== (n < total)) begin errors++; $display("FAIL rand_busy frame %0d tick %0d got %0b exp %0b", f, n, busy, (n < total)); end
                trig = 1'($urandom);
                if (trig) n++;
            end
            // Final counted tick is applied on this edge; busy must now fall.
            cyc();
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_end frame %0d got %0b exp 0", f, busy); end
        end
        v0 = 0; v1 = 0; trig = 0;
    endtask

    // Reset at SENDING tick 5 aborts the frame without replay.
    task automatic test_reset_abort();
        int g;
        do_reset();
        v0 = 1; d0 = 8'h5A; c0 = 0; trig = 1;
        cyc();
        checks++; if (start !== 1'b1) begin errors++; $display("FAIL abort_launch got %0b exp 1", start); end
        v0 = 0;
        cyc();
        repeat (5) cyc();
        #1 rst = 1'b1;
        #1;
        checks++; if ({data, crc, start, busy} !== 11'h0) begin errors++; $display("FAIL abort_outputs got %0h exp 0", {data, crc, start, busy}); end
        checks++; if (grant !== 1'b1) begin errors++; $display("FAIL abort_grant got %0b exp 1", grant); end
        cyc();
        rst = 1'b0;
        g = 0;
        for (int i = 0; i < 40; i++) begin cyc(); if (start || busy) g++; end
        checks++; if (g !== 0) begin errors++; $display("FAIL abort_replay got %0d active cycles exp 0", g); end
        v1 = 1; d1 = 8'hC3;
        #1;
        checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL abort_new_ready got %0b exp 1", r1); end
        cyc();
        checks++; if (start !== 1'b1 || data !== 8'hC3) begin errors++; $display("FAIL abort_new_start got %0b/%0h exp 1/c3", start, data); end
        v1 = 0;
        for (int i = 0; i < 40 && busy; i++) cyc();
        trig = 0;
    endtask

    // No gap, trigger always high: start pulses every 2 + frame ticks cycles.
    task automatic test_back_to_back();
        for (int m = 0; m < 2; m++) begin
            int t[$];
            int exp_sp;
            z_v0 = 0;
            repeat (30) cyc();
            z_trig = 1; z_c0 = 1'(m); z_d0 = 8'($urandom); z_v0 = 1;
            exp_sp = m ? 21 : 13;
            for (int i = 0; i < 300 && t.size() < 4; i++) begin
                cyc();
                if (z_start) t.push_back(i);
            end
            checks++; if (t.size() !== 4) begin errors++; $display("FAIL b2b_count got %0d exp 4", t.size()); end
            for (int k = 1; k < t.size(); k++) begin
                checks++; if (t[k] - t[k-1] !== exp_sp) begin errors++; $display("FAIL b2b_spacing got %0d exp %0d", t[k] - t[k-1], exp_sp); end
            end
        end
        z_v0 = 0;
        z_trig = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_random();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter FRAME_TICKS, default 11, giving the number of trigger_i pulses in one frame without CRC (start + 8 data + parity + stop).
REQ-002 SHALL have parameter FRAME_TICKS_CRC, default 19, giving the number of trigger_i pulses in one frame with CRC (adds 8 CRC bits).
REQ-003 SHALL have parameter GAP_TICKS, default 1, giving the idle trigger_i pulses inserted between frames; legal range 0..31.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: asynchronous active-high reset.
REQ-006 SHALL have port trigger_i, input, 1 bit: baud tick, the same strobe that feeds uart_tx.
REQ-007 SHALL have ports req0_valid_i / req1_valid_i, input, 1 bit each: requester has a byte pending.
REQ-008 SHALL have ports req0_data_i / req1_data_i, input, 8 bits each: requester byte.
REQ-009 SHALL have ports req0_crc_en_i / req1_crc_en_i, input, 1 bit each: append CRC to this frame.
REQ-010 SHALL have ports req0_ready_o / req1_ready_o, output, 1 bit each: byte accepted this cycle when ready and valid are both high.
REQ-011 SHALL have port data_o, output, 8 bits: byte to uart_tx data_i.
REQ-012 SHALL have port crc_en_o, output, 1 bit: to uart_tx crc_en_i.
REQ-013 SHALL have port tx_start_cmd_o, output, 1 bit: one-cycle start pulse to uart_tx tx_start_cmd_i.
REQ-014 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port grant_o, output, 1 bit: index of the requester owning the current or most recent frame.

Function
REQ-016 SHALL implement the states IDLE, LAUNCH, SENDING and GAP.
REQ-017 In IDLE, the scheduler SHALL combinationally assert readyN_o only for the requester selected by round-robin; readyN_o is 0 in all other states.
REQ-018 Round-robin: when only one requester is valid, that requester SHALL be selected; when both are valid, the requester not equal to grant_o SHALL be selected.
REQ-019 On acceptance (IDLE, valid and ready high), the scheduler SHALL latch data and crc_en into data_o/crc_en_o, update grant_o, and go to LAUNCH.
REQ-020 data_o and crc_en_o SHALL hold stable from the acceptance edge until the next acceptance.
REQ-021 LAUNCH SHALL last exactly one cycle with tx_start_cmd_o=1, then go to SENDING with the tick counter cleared; tx_start_cmd_o is 0 in all other cycles.
REQ-022 SENDING SHALL count clock cycles with trigger_i=1, starting the cycle after LAUNCH; a trigger_i during LAUNCH is not counted.
REQ-023 When the count reaches FRAME_TICKS_CRC if crc_en_o=1, or FRAME_TICKS otherwise, the scheduler SHALL clear the counter and go to GAP, or to IDLE if GAP_TICKS=0.
REQ-024 GAP SHALL count GAP_TICKS trigger_i pulses, then go to IDLE.
REQ-025 The tick counter SHALL be 5 bits and SHALL never wrap, since the terminal compare occurs first.
REQ-026 A request arriving or withdrawn while not in IDLE SHALL be ignored until IDLE, with no acceptance and no lost state.
REQ-027 Minimum spacing between tx_start_cmd_o pulses SHALL be 2 + frame ticks + GAP_TICKS trigger pulses.

Reset
REQ-028 When rst_i=1, the scheduler SHALL immediately go to IDLE, asynchronously, with data_o=0, crc_en_o=0, tx_start_cmd_o=0, busy_o=0, grant_o=1 (so req0 wins the first tie), counter=0.
REQ-029 Reset asserted mid-LAUNCH or mid-SENDING SHALL abort the frame with no further start pulse, and the aborted request SHALL NOT be replayed.
REQ-030 After reset deasserts, the scheduler SHALL accept a request no earlier than the first rising edge where rst_i=0.

Verification
REQ-031 After reset, req0 valid with 0xA5, crc_en=0 -> req0_ready_o=1 for one cycle, next cycle tx_start_cmd_o=1 with data_o=0xA5, busy_o drops exactly after 11+1 trigger pulses.
REQ-032 Both requesters valid continuously, req0=0x11 and req1=0x22 -> start pulses carry 0x11, 0x22, 0x11, 0x22 with grant_o alternating 0,1,0,1.
REQ-033 req1 with crc_en=1 -> busy_o stays high for 19 SENDING ticks + 1 GAP tick; crc_en_o=1 throughout.
REQ-034 trigger_i held high every cycle, GAP_TICKS=0 -> back-to-back frames with exactly 2+11 cycles between start pulses; the LAUNCH-cycle tick is not counted.
REQ-035 rst_i pulsed at SENDING tick 5 -> all outputs 0 and grant_o=1 immediately; no tx_start_cmd_o until a new request arrives.
REQ-036 req0_valid_i toggled during SENDING -> no ready asserted and no extra start pulse until IDLE.
